// File: rtl/sf48_pkg.sv
// Shared definitions for the 48 kHz stereo sum/difference scaling stage.
//   W, KW        sample and gain widths
//   FRAC, ROUND  Q1.3 gain: round half up by adding ROUND, then shifting FRAC
//   MAXV, MINV   saturation limits of a W-bit signed result
//   state_t      sequencer states
//   sat_round()  round/shift/saturate of a full-width product
package sf48_pkg;

  localparam int W     = 18;
  localparam int KW    = 4;
  localparam int FRAC  = 3;
  localparam int ROUND = 4;
  localparam int PW    = W + KW + 1;
  localparam int MAXV  = (1 << (W - 1)) - 1;
  localparam int MINV  = -(1 << (W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIFF = 2'd2
  } state_t;

  typedef struct packed {
    logic              sat;
    logic signed [W-1:0] val;
  } sr_t;

  // One guard bit above the product so the rounding add cannot wrap.
  function automatic sr_t sat_round(input logic signed [PW-1:0] prod);
    logic signed [PW:0] r;
    sr_t                res;
    r = (PW+1)'(prod) + (PW+1)'(ROUND);
    r = r >>> FRAC;
    if (r > (PW+1)'(MAXV)) begin
      res.sat = 1'b1;
      res.val = W'(MAXV);
    end else if (r < (PW+1)'(MINV)) begin
      res.sat = 1'b1;
      res.val = W'(MINV);
    end else begin
      res.sat = 1'b0;
      res.val = r[W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sf48_scale_round.sv
// Combinational scale/round/saturate unit.
//   operand  in  W+1  signed sum or difference of the working pair
//   gain     in  KW   unsigned Q1.3 gain
//   result   out W    rounded, saturated product
//   sat      out 1    result was clipped
module sf48_scale_round
  import sf48_pkg::*;
(
  input  logic signed [W:0]    operand,
  input  logic        [KW-1:0] gain,
  output logic signed [W-1:0]  result,
  output logic                 sat
);

  logic signed [PW-1:0] prod;
  sr_t                  sr;

  always_comb begin
    // Gain is zero-extended before the signed multiply so 15 stays +15.
    prod   = PW'(operand) * $signed(PW'(gain));
    sr     = sat_round(prod);
    result = sr.val;
    sat    = sr.sat;
  end

endmodule

// File: rtl/block_sf_48_sched.sv
// Sequencer for the stereo sum/difference scaling stage. One LEFT/RIGHT pair
// is taken per sample tick; a single scale unit is used for (L+R)*Ks in SUM
// and (L-R)*Kd in DIFF.
//   clock, reset              clock; asynchronous active-low reset
//   in_valid/in_ready         1-deep input buffer handshake
//   LEFT, RIGHT               signed W-bit samples
//   Ks, Kd, cfg_load          gains captured into shadow registers
//   LI_in_LpR/ready_out_LpR   scaled L+R and its update pulse
//   LI_in_LmR/ready_out_LmR   scaled L-R and its update pulse
//   sat_flag                  sticky saturation indicator
//   underrun                  pulse: tick found the buffer empty
module block_sf_48_sched
  import sf48_pkg::*;
#(
  parameter int unsigned DIV = 1042
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] LEFT,
  input  logic signed [W-1:0] RIGHT,
  input  logic        [KW-1:0] Ks,
  input  logic        [KW-1:0] Kd,
  input  logic                cfg_load,
  output logic signed [W-1:0] LI_in_LpR,
  output logic signed [W-1:0] LI_in_LmR,
  output logic                ready_out_LpR,
  output logic                ready_out_LmR,
  output logic                sat_flag,
  output logic                underrun
);

  localparam int unsigned   CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  state_t              state, state_d;
  logic [CW-1:0]       cnt;
  logic                tick, start, load;
  logic                buf_full;
  logic signed [W-1:0] buf_l, buf_r, work_l, work_r;
  logic [KW-1:0]       ks_sh, kd_sh, ks_act, kd_act;
  logic signed [W:0]   operand;
  logic [KW-1:0]       gain;
  logic signed [W-1:0] result;
  logic                sat;

  assign tick     = (cnt == LAST);
  // Held low through SUM as well, so it rises only the cycle after SUM.
  assign in_ready = ~buf_full & (state != SUM);
  assign load     = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_d = SUM;
        start   = 1'b1;
      end
      SUM:     state_d = DIFF;
      DIFF:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state == DIFF) begin
      operand = (W+1)'(work_l) - (W+1)'(work_r);
      gain    = kd_act;
    end else begin
      operand = (W+1)'(work_l) + (W+1)'(work_r);
      gain    = ks_act;
    end
  end

  sf48_scale_round u_scale (
    .operand (operand),
    .gain    (gain),
    .result  (result),
    .sat     (sat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      buf_full      <= 1'b0;
      buf_l         <= '0;
      buf_r         <= '0;
      work_l        <= '0;
      work_r        <= '0;
      ks_sh         <= '0;
      kd_sh         <= '0;
      ks_act        <= '0;
      kd_act        <= '0;
      LI_in_LpR     <= '0;
      LI_in_LmR     <= '0;
      ready_out_LpR <= 1'b0;
      ready_out_LmR <= 1'b0;
      sat_flag      <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);

      if (cfg_load) begin
        ks_sh <= Ks;
        kd_sh <= Kd;
      end

      // A handshake in the SUM-entry cycle only happens with the buffer
      // already empty, so loading takes priority over freeing.
      if (load) begin
        buf_full <= 1'b1;
        buf_l    <= LEFT;
        buf_r    <= RIGHT;
      end else if (start) begin
        buf_full <= 1'b0;
      end

      if (start) begin
        ks_act <= cfg_load ? Ks : ks_sh;
        kd_act <= cfg_load ? Kd : kd_sh;
        if (buf_full) begin
          work_l <= buf_l;
          work_r <= buf_r;
        end
      end

      underrun      <= start & ~buf_full;
      ready_out_LpR <= (state == SUM);
      ready_out_LmR <= (state == DIFF);
      if (state == SUM)  LI_in_LpR <= result;
      if (state == DIFF) LI_in_LmR <= result;
      if ((state == SUM || state == DIFF) && sat) sat_flag <= 1'b1;
    end
  end

  tick_only_in_idle: assert property (
    @(posedge clock) disable iff (!reset) tick |-> state == IDLE
  ) else $error("tick outside IDLE");

endmodule

// File: tb/tb_block_sf_48_sched.sv
module tb_block_sf_48_sched;

  localparam int unsigned DIV = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] LEFT = '0;
  logic signed [17:0] RIGHT = '0;
  logic [3:0]         Ks = '0;
  logic [3:0]         Kd = '0;
  logic               cfg_load = 1'b0;
  logic signed [17:0] LI_in_LpR;
  logic signed [17:0] LI_in_LmR;
  logic               ready_out_LpR;
  logic               ready_out_LmR;
  logic               sat_flag;
  logic               underrun;

  block_sf_48_sched #(.DIV(DIV)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .LEFT          (LEFT),
    .RIGHT         (RIGHT),
    .Ks            (Ks),
    .Kd            (Kd),
    .cfg_load      (cfg_load),
    .LI_in_LpR     (LI_in_LpR),
    .LI_in_LmR     (LI_in_LmR),
    .ready_out_LpR (ready_out_LpR),
    .ready_out_LmR (ready_out_LmR),
    .sat_flag      (sat_flag),
    .underrun      (underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int l; int r; int ks; int kd; int lpr; int lmr; int sat;
  } vec_t;

  vec_t vecs[6];
  int   q_lpr[$];
  int   q_lmr[$];
  int   last_lpr = 0;
  int   last_lmr = 0;
  int   tests = 0;
  int   fails = 0;
  int   lpr_cnt = 0;
  int   urun_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: (a*k + 4) >>> 3, clipped to 18-bit signed range.
  function automatic int model(input int a, input int k);
    int p;
    p = (a * k + 4) >>> 3;
    if (p > 131071) p = 131071;
    if (p < -131072) p = -131072;
    return p;
  endfunction

  // Scoreboard: each ready pulse pops its expectation; an empty queue means
  // an underrun tick, which must repeat the previous value.
  initial forever begin
    int e;
    @(posedge clock);
    #1;
    if (ready_out_LpR || ready_out_LmR)
      check("pulse_overlap", int'(ready_out_LpR & ready_out_LmR), 0);
    if (ready_out_LpR) begin
      e = (q_lpr.size() > 0) ? q_lpr.pop_front() : last_lpr;
      last_lpr = e;
      check("LpR_data", int'(LI_in_LpR), e);
      lpr_cnt++;
    end
    if (ready_out_LmR) begin
      e = (q_lmr.size() > 0) ? q_lmr.pop_front() : last_lmr;
      last_lmr = e;
      check("LmR_data", int'(LI_in_LmR), e);
    end
    if (underrun) urun_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_lmr();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ready_out_LmR && n < 4 * DIV);
    if (!ready_out_LmR) check("wait_LmR_timeout", 0, 1);
  endtask

  task automatic wait_lpr();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ready_out_LpR && n < 4 * DIV);
    if (!ready_out_LpR) check("wait_LpR_timeout", 0, 1);
  endtask

  // Called right after reset release: first tick DIV cycles later, then
  // underrun at t+1, LpR at t+2, LmR at t+3.
  task automatic measure_first_tick();
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!underrun && n < 4 * DIV);
    check("first_tick_latency", n, DIV);
    @(posedge clock); #1;
    check("LpR_at_t2", int'(ready_out_LpR), 1);
    @(posedge clock); #1;
    check("LmR_at_t3", int'(ready_out_LmR), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_LpR"}, int'(LI_in_LpR), 0);
    check({tag, "_LmR"}, int'(LI_in_LmR), 0);
    check({tag, "_rdy_LpR"}, int'(ready_out_LpR), 0);
    check({tag, "_rdy_LmR"}, int'(ready_out_LmR), 0);
    check({tag, "_sat"}, int'(sat_flag), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    int u0, l0, acc, n, l, r;
    bit took;

    vecs[0] = '{15, 32, 8, 12, 47, -25, 0};
    vecs[1] = '{131071, 131071, 15, 8, 131071, 0, 1};
    vecs[2] = '{-131072, 131071, 8, 15, -1, -131072, 1};
    vecs[3] = '{100, -50, 12, 15, 75, 281, 1};
    vecs[4] = '{-7, -9, 15, 1, -30, 0, 1};
    vecs[5] = '{3, 0, 8, 8, 3, 3, 1};

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b1;
    // Empty buffer at the first tick: underrun emitting zeros.
    measure_first_tick();
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      Ks = 4'(vecs[i].ks);
      Kd = 4'(vecs[i].kd);
      cfg_load = 1'b1;
      LEFT = 18'(vecs[i].l);
      RIGHT = 18'(vecs[i].r);
      in_valid = 1'b1;
      check("vec_in_ready", int'(in_ready), 1);
      q_lpr.push_back(vecs[i].lpr);
      q_lmr.push_back(vecs[i].lmr);
      @(negedge clock);
      cfg_load = 1'b0;
      in_valid = 1'b0;
      check("vec_ready_drop", int'(in_ready), 0);
      wait_lmr();
      check("vec_sat_flag", int'(sat_flag), vecs[i].sat);
    end

    // Underrun: no pair offered, previous outputs re-emitted.
    u0 = urun_cnt;
    wait_lmr();
    check("underrun_pulses", urun_cnt - u0, 1);

    // Gain change while a sample is in DIFF.
    Ks = 4'd8; Kd = 4'd8; cfg_load = 1'b1;
    LEFT = 18'sd16; RIGHT = 18'sd0; in_valid = 1'b1;
    q_lpr.push_back(16);
    q_lmr.push_back(16);
    @(negedge clock);
    cfg_load = 1'b0; in_valid = 1'b0;
    wait_lpr();
    Ks = 4'd12; Kd = 4'd4; cfg_load = 1'b1;
    q_lpr.push_back(24);
    q_lmr.push_back(8);
    @(negedge clock);
    cfg_load = 1'b0;
    wait_lmr();
    u0 = urun_cnt;
    wait_lmr();
    check("gain_underrun", urun_cnt - u0, 1);

    // Continuous in_valid: one pair per tick, none lost or duplicated.
    u0 = urun_cnt; l0 = lpr_cnt; acc = 0; n = 0;
    l = 1000; r = -2000;
    Ks = 4'd12; Kd = 4'd10; cfg_load = 1'b1; in_valid = 1'b1;
    while (acc < 10 && n < 20 * DIV) begin
      LEFT = 18'(l); RIGHT = 18'(r);
      took = in_ready;
      if (took) begin
        q_lpr.push_back(model(l + r, 12));
        q_lmr.push_back(model(l - r, 10));
        acc++;
        l += 5;
        r -= 7;
      end
      @(negedge clock);
      cfg_load = 1'b0;
      n++;
      if (took) check("hs_ready_low_after_load", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    check("hs_accepted", acc, 10);
    wait_lmr();
    check("hs_ticks", lpr_cnt - l0, 10);
    check("hs_no_underrun", urun_cnt - u0, 0);

    // Reset during DIFF.
    LEFT = 18'sd5; RIGHT = 18'sd5; in_valid = 1'b1;
    q_lpr.push_back(model(10, 12));
    @(negedge clock);
    in_valid = 1'b0;
    wait_lpr();
    reset = 1'b0;
    #1;
    q_lpr.delete();
    q_lmr.delete();
    last_lpr = 0;
    last_lmr = 0;
    check_idle_outputs("mid_reset");
    @(negedge clock);
    check("reset_no_LmR_pulse", int'(ready_out_LmR), 0);
    @(negedge clock);
    reset = 1'b1;
    measure_first_tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
